// File: rtl/prog_mode_ctrl_pkg.sv
// Shared constants and state encoding for the run/program-mode controller.
package prog_ctrl_pkg;

  localparam int UPG_ADR_W   = 15;
  localparam int UPG_SEL_BIT = 14;
  localparam int MEM_ADDR_W  = 14;
  localparam int PROG_CNT_W  = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ARM     = 2'd1,
    PROG    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // The UART programmer owns both memory ports in ARM and PROG.
  function automatic logic uart_owns(input state_t s);
    return (s == ARM) || (s == PROG);
  endfunction

endpackage

// File: rtl/prog_mode_ctrl_if.sv
// Bundle of programmer, CPU and memory-port signals around the mode controller.
interface prog_mode_ctrl_if;
  import prog_ctrl_pkg::*;

  logic                  upg_wen;
  logic [UPG_ADR_W-1:0]  upg_adr;
  logic [31:0]           upg_dat;
  logic                  upg_done;
  logic [MEM_ADDR_W-1:0] cpu_imem_addr;
  logic [MEM_ADDR_W-1:0] cpu_dmem_addr;
  logic                  cpu_dmem_wen;
  logic [31:0]           cpu_dmem_wdata;
  logic [MEM_ADDR_W-1:0] imem_addr;
  logic                  imem_wen;
  logic [31:0]           imem_wdata;
  logic [MEM_ADDR_W-1:0] dmem_addr;
  logic                  dmem_wen;
  logic [31:0]           dmem_wdata;
  logic                  cpu_rst;
  logic                  upg_rst;
  logic                  prog_mode;
  logic [PROG_CNT_W-1:0] prog_words;

  modport master (
    output upg_wen, upg_adr, upg_dat, upg_done,
    output cpu_imem_addr, cpu_dmem_addr, cpu_dmem_wen, cpu_dmem_wdata,
    input  imem_addr, imem_wen, imem_wdata, dmem_addr, dmem_wen, dmem_wdata,
    input  cpu_rst, upg_rst, prog_mode, prog_words
  );

  modport slave (
    input  upg_wen, upg_adr, upg_dat, upg_done,
    input  cpu_imem_addr, cpu_dmem_addr, cpu_dmem_wen, cpu_dmem_wdata,
    output imem_addr, imem_wen, imem_wdata, dmem_addr, dmem_wen, dmem_wdata,
    output cpu_rst, upg_rst, prog_mode, prog_words
  );

endinterface

// File: rtl/prog_mode_ctrl_btn_debounce.sv
// Two-flop synchronizer plus saturating hold counter; emits one pulse per stable press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic i_clock,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LP_PRE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (!r_sync2) begin
        r_cnt <= '0;
      end else if (r_cnt != LP_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Fires alongside the counter landing on its maximum; saturation blocks re-fire.
      r_pulse <= r_sync2 && (r_cnt == LP_PRE);
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/prog_mode_ctrl.sv
// Sequences CPU reset around UART reprogramming sessions and muxes the memory write ports.
module prog_mode_ctrl
  import prog_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic             i_clock,
  input  logic             i_fpga_rst_n,
  input  logic             i_start_pg,
  prog_mode_ctrl_if.slave  bus
);

  logic                  w_pg_req;
  state_t                r_state;
  state_t                w_state_next;
  logic                  r_cpu_rst;
  logic                  w_cpu_rst_next;
  logic                  r_upg_rst;
  logic                  w_upg_rst_next;
  logic                  r_prog_mode;
  logic                  w_prog_mode_next;
  logic [PROG_CNT_W-1:0] r_prog_words;
  logic [PROG_CNT_W-1:0] w_prog_words_next;
  logic                  w_uart;
  logic                  w_sel_dmem;
  logic                  w_upg_wen_ok;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_debounce (
    .i_clock (i_clock),
    .i_rst_n (i_fpga_rst_n),
    .i_btn   (i_start_pg),
    .o_pulse (w_pg_req)
  );

  always_ff @(posedge i_clock or negedge i_fpga_rst_n) begin
    if (!i_fpga_rst_n) begin
      r_state      <= RUN;
      r_cpu_rst    <= 1'b1;
      r_upg_rst    <= 1'b1;
      r_prog_mode  <= 1'b0;
      r_prog_words <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cpu_rst    <= w_cpu_rst_next;
      r_upg_rst    <= w_upg_rst_next;
      r_prog_mode  <= w_prog_mode_next;
      r_prog_words <= w_prog_words_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cpu_rst_next    = r_cpu_rst;
    w_upg_rst_next    = r_upg_rst;
    w_prog_mode_next  = r_prog_mode;
    w_prog_words_next = r_prog_words;
    case (r_state)
      RUN: begin
        // Also releases the CPU on the first edge after power-on reset.
        w_cpu_rst_next   = 1'b0;
        w_upg_rst_next   = 1'b1;
        w_prog_mode_next = 1'b0;
        if (w_pg_req) begin
          w_state_next   = ARM;
          w_cpu_rst_next = 1'b1;
        end
      end
      ARM: begin
        w_prog_words_next = '0;
        w_prog_mode_next  = 1'b1;
        w_upg_rst_next    = 1'b0;
        w_cpu_rst_next    = 1'b1;
        w_state_next      = PROG;
      end
      PROG: begin
        w_cpu_rst_next = 1'b1;
        if (bus.upg_wen && (r_prog_words != '1)) begin
          w_prog_words_next = r_prog_words + 1'b1;
        end
        if (bus.upg_done) begin
          w_state_next     = RELEASE;
          w_prog_mode_next = 1'b0;
          w_upg_rst_next   = 1'b1;
        end
      end
      RELEASE: begin
        w_cpu_rst_next   = 1'b0;
        w_upg_rst_next   = 1'b1;
        w_prog_mode_next = 1'b0;
        w_state_next     = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  assign w_uart       = uart_owns(r_state);
  assign w_sel_dmem   = bus.upg_adr[UPG_SEL_BIT];
  assign w_upg_wen_ok = bus.upg_wen && (r_state == PROG);

  always_comb begin
    if (w_uart) begin
      bus.imem_addr  = bus.upg_adr[MEM_ADDR_W-1:0];
      bus.imem_wdata = bus.upg_dat;
      bus.imem_wen   = w_upg_wen_ok && !w_sel_dmem;
      bus.dmem_addr  = bus.upg_adr[MEM_ADDR_W-1:0];
      bus.dmem_wdata = bus.upg_dat;
      bus.dmem_wen   = w_upg_wen_ok && w_sel_dmem;
    end else begin
      bus.imem_addr  = bus.cpu_imem_addr;
      bus.imem_wdata = '0;
      bus.imem_wen   = 1'b0;
      bus.dmem_addr  = bus.cpu_dmem_addr;
      bus.dmem_wdata = bus.cpu_dmem_wdata;
      bus.dmem_wen   = bus.cpu_dmem_wen && !r_cpu_rst;
    end
  end

  assign bus.cpu_rst    = r_cpu_rst;
  assign bus.upg_rst    = r_upg_rst;
  assign bus.prog_mode  = r_prog_mode;
  assign bus.prog_words = r_prog_words;

endmodule

// File: tb/tb_prog_mode_ctrl.sv
// Randomized scenario bench for prog_mode_ctrl with a timeline-based expectation model.
module tb_prog_mode_ctrl;

  localparam int PH_CPU  = 0;
  localparam int PH_ARM  = 1;
  localparam int PH_UART = 2;
  localparam int REQ_TO_RST = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_pg = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_words = 0;
  int   k_rise;

  prog_mode_ctrl_if bus ();

  prog_mode_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .i_clock      (clk),
    .i_fpga_rst_n (rst_n),
    .i_start_pg   (start_pg),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  logic [93:0] act_ports;
  logic [18:0] act_stat;
  assign act_ports = {bus.imem_addr, bus.imem_wen, bus.imem_wdata,
                      bus.dmem_addr, bus.dmem_wen, bus.dmem_wdata};
  assign act_stat  = {bus.cpu_rst, bus.upg_rst, bus.prog_mode, bus.prog_words};

  // Expected memory-port view given who owns the ports and whether the CPU is held in reset.
  function automatic logic [93:0] exp_ports(input int ph, input logic rst_exp);
    logic [93:0] v;
    logic        wi;
    logic        wd;
    if (ph == PH_CPU) begin
      v = {bus.cpu_imem_addr, 1'b0, 32'h0, bus.cpu_dmem_addr,
           bus.cpu_dmem_wen & ~rst_exp, bus.cpu_dmem_wdata};
    end else begin
      wi = (ph == PH_UART) && bus.upg_wen && !bus.upg_adr[14];
      wd = (ph == PH_UART) && bus.upg_wen && bus.upg_adr[14];
      v = {bus.upg_adr[13:0], wi, bus.upg_dat, bus.upg_adr[13:0], wd, bus.upg_dat};
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs(input logic wen);
    bus.cpu_imem_addr  = 14'($urandom);
    bus.cpu_dmem_addr  = 14'($urandom);
    bus.cpu_dmem_wen   = 1'($urandom);
    bus.cpu_dmem_wdata = $urandom;
    bus.upg_adr        = 15'($urandom);
    bus.upg_dat        = $urandom;
    bus.upg_wen        = wen;
  endtask

  task automatic wait_rise();
    k_rise = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.cpu_rst === 1'b1) begin
        k_rise = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rand_inputs(1'b0);
    bus.cpu_dmem_wen = 1'b1;
    bus.upg_done = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    n_tests++;
    if (act_stat !== {3'b110, 16'h0}) begin
      n_fail++; $display("FAIL reset_stat: got %h expected %h", act_stat, {3'b110, 16'h0});
    end
    n_tests++;
    if (act_ports !== exp_ports(PH_CPU, 1'b1)) begin
      n_fail++; $display("FAIL reset_ports: got %h expected %h", act_ports, exp_ports(PH_CPU, 1'b1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_tests++;
    if (act_stat !== {3'b010, 16'h0}) begin
      n_fail++; $display("FAIL reset_release: got %h expected %h", act_stat, {3'b010, 16'h0});
    end
    for (int i = 0; i < 6; i++) begin
      rand_inputs(1'($urandom));
      #1;
      n_tests++;
      if (act_ports !== exp_ports(PH_CPU, 1'b0)) begin
        n_fail++; $display("FAIL run_ports: got %h expected %h", act_ports, exp_ports(PH_CPU, 1'b0));
      end
      step();
    end
    $display("[TB] reset: done");
  endtask

  task automatic test_debounce();
    int first_rst = 0;
    int first_pm = 0;
    for (int i = 0; i < 4; i++) begin
      start_pg = (i % 2 == 0);
      step();
    end
    start_pg = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (bus.cpu_rst === 1'b1 && first_rst == 0) first_rst = k;
      if (bus.prog_mode === 1'b1 && first_pm == 0) first_pm = k;
      if (k == REQ_TO_RST) begin
        n_tests++;
        if (bus.upg_rst !== 1'b1) begin
          n_fail++; $display("FAIL arm_upg_rst: got %b expected 1", bus.upg_rst);
        end
        rand_inputs(1'b1);
        bus.upg_adr[14] = 1'b0;
        #1;
        n_tests++;
        if (act_ports !== exp_ports(PH_ARM, 1'b1)) begin
          n_fail++; $display("FAIL arm_ports: got %h expected %h", act_ports, exp_ports(PH_ARM, 1'b1));
        end
        bus.upg_wen = 1'b0;
      end
      if (k == REQ_TO_RST + 1) begin
        start_pg = 1'b0;
        break;
      end
    end
    n_tests++;
    if (first_rst != REQ_TO_RST) begin
      n_fail++; $display("FAIL press_latency: got %0d expected %0d", first_rst, REQ_TO_RST);
    end
    n_tests++;
    if (first_pm != REQ_TO_RST + 1) begin
      n_fail++; $display("FAIL prog_mode_latency: got %0d expected %0d", first_pm, REQ_TO_RST + 1);
    end
    exp_words = 0;
    $display("[TB] debounce: cpu_rst at %0d, prog_mode at %0d", first_rst, first_pm);
  endtask

  task automatic test_prog_writes();
    for (int i = 0; i < 22; i++) begin
      rand_inputs((i < 2) ? 1'b1 : 1'($urandom));
      bus.cpu_dmem_wen = 1'b1;
      if (i == 0) begin
        bus.upg_adr = 15'h0003; bus.upg_dat = 32'h2008000A;
      end else if (i == 1) begin
        bus.upg_adr = 15'h4005; bus.upg_dat = 32'hDEADBEEF;
      end
      #1;
      n_tests++;
      if (act_ports !== exp_ports(PH_UART, 1'b1)) begin
        n_fail++; $display("FAIL prog_ports[%0d]: got %h expected %h", i, act_ports, exp_ports(PH_UART, 1'b1));
      end
      if (bus.upg_wen) exp_words++;
      step();
      if (i == 1) begin
        n_tests++;
        if (bus.prog_words !== 16'd2) begin
          n_fail++; $display("FAIL two_words: got %0d expected 2", bus.prog_words);
        end
      end
    end
    n_tests++;
    if (act_stat !== {3'b101, 16'(exp_words)}) begin
      n_fail++; $display("FAIL prog_stat: got %h expected %h", act_stat, {3'b101, 16'(exp_words)});
    end
    $display("[TB] prog_writes: %0d words", exp_words);
  endtask

  task automatic test_done_same_cycle();
    rand_inputs(1'b1);
    bus.upg_done = 1'b1;
    #1;
    n_tests++;
    if (act_ports !== exp_ports(PH_UART, 1'b1)) begin
      n_fail++; $display("FAIL done_wr_ports: got %h expected %h", act_ports, exp_ports(PH_UART, 1'b1));
    end
    exp_words++;
    step();
    bus.upg_done = 1'b0;
    n_tests++;
    if (act_stat !== {3'b110, 16'(exp_words)}) begin
      n_fail++; $display("FAIL release_stat: got %h expected %h", act_stat, {3'b110, 16'(exp_words)});
    end
    rand_inputs(1'b0);
    bus.cpu_dmem_wen = 1'b1;
    #1;
    n_tests++;
    if (act_ports !== exp_ports(PH_CPU, 1'b1)) begin
      n_fail++; $display("FAIL release_ports: got %h expected %h", act_ports, exp_ports(PH_CPU, 1'b1));
    end
    step();
    n_tests++;
    if (act_stat !== {3'b010, 16'(exp_words)}) begin
      n_fail++; $display("FAIL restart_stat: got %h expected %h", act_stat, {3'b010, 16'(exp_words)});
    end
    for (int i = 0; i < 5; i++) begin
      rand_inputs(1'($urandom));
      #1;
      n_tests++;
      if (act_ports !== exp_ports(PH_CPU, 1'b0)) begin
        n_fail++; $display("FAIL run_hold_ports: got %h expected %h", act_ports, exp_ports(PH_CPU, 1'b0));
      end
      step();
    end
    n_tests++;
    if (bus.prog_words !== 16'(exp_words)) begin
      n_fail++; $display("FAIL words_hold: got %0d expected %0d", bus.prog_words, exp_words);
    end
    bus.upg_wen = 1'b0;
    $display("[TB] done_same_cycle: words %0d", exp_words);
  endtask

  task automatic test_done_on_entry();
    rand_inputs(1'b0);
    bus.upg_done = 1'b1;
    start_pg = 1'b1;
    wait_rise();
    n_tests++;
    if (k_rise != REQ_TO_RST) begin
      n_fail++; $display("FAIL entry_press: got %0d expected %0d", k_rise, REQ_TO_RST);
    end
    step();
    start_pg = 1'b0;
    n_tests++;
    if (act_stat !== {3'b101, 16'h0}) begin
      n_fail++; $display("FAIL entry_prog: got %h expected %h", act_stat, {3'b101, 16'h0});
    end
    step();
    n_tests++;
    if (act_stat !== {3'b110, 16'h0}) begin
      n_fail++; $display("FAIL entry_release: got %h expected %h", act_stat, {3'b110, 16'h0});
    end
    step();
    n_tests++;
    if (act_stat !== {3'b010, 16'h0}) begin
      n_fail++; $display("FAIL entry_run: got %h expected %h", act_stat, {3'b010, 16'h0});
    end
    bus.upg_done = 1'b0;
    exp_words = 0;
    for (int i = 0; i < 4; i++) step();
    $display("[TB] done_on_entry: done");
  endtask

  task automatic test_reset_mid_prog();
    start_pg = 1'b1;
    wait_rise();
    n_tests++;
    if (k_rise != REQ_TO_RST) begin
      n_fail++; $display("FAIL mid_press: got %0d expected %0d", k_rise, REQ_TO_RST);
    end
    step();
    start_pg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(1'b1);
      step();
    end
    rand_inputs(1'b1);
    bus.upg_adr[14] = 1'b0;
    bus.cpu_dmem_wen = 1'b1;
    #1;
    n_tests++;
    if (bus.imem_wen !== 1'b1) begin
      n_fail++; $display("FAIL mid_wen_pre: got %b expected 1", bus.imem_wen);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (act_ports !== exp_ports(PH_CPU, 1'b1)) begin
      n_fail++; $display("FAIL mid_reset_ports: got %h expected %h", act_ports, exp_ports(PH_CPU, 1'b1));
    end
    n_tests++;
    if (act_stat !== {3'b110, 16'h0}) begin
      n_fail++; $display("FAIL mid_reset_stat: got %h expected %h", act_stat, {3'b110, 16'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.upg_wen = 1'b0;
    step();
    n_tests++;
    if (act_stat !== {3'b010, 16'h0}) begin
      n_fail++; $display("FAIL mid_after: got %h expected %h", act_stat, {3'b010, 16'h0});
    end
    rand_inputs(1'b1);
    #1;
    n_tests++;
    if (act_ports !== exp_ports(PH_CPU, 1'b0)) begin
      n_fail++; $display("FAIL mid_run_ports: got %h expected %h", act_ports, exp_ports(PH_CPU, 1'b0));
    end
    bus.upg_wen = 1'b0;
    exp_words = 0;
    step();
    $display("[TB] reset_mid_prog: done");
  endtask

  task automatic test_hold_through();
    int n_rises = 0;
    rand_inputs(1'b0);
    bus.upg_done = 1'b0;
    start_pg = 1'b1;
    wait_rise();
    n_tests++;
    if (k_rise != REQ_TO_RST) begin
      n_fail++; $display("FAIL hold_press: got %0d expected %0d", k_rise, REQ_TO_RST);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      rand_inputs(1'b1);
      step();
    end
    bus.upg_wen = 1'b0;
    bus.upg_done = 1'b1;
    step();
    bus.upg_done = 1'b0;
    step();
    n_tests++;
    if (act_stat !== {3'b010, 16'd2}) begin
      n_fail++; $display("FAIL hold_session: got %h expected %h", act_stat, {3'b010, 16'd2});
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.cpu_rst !== 1'b0) n_rises++;
    end
    n_tests++;
    if (n_rises != 0) begin
      n_fail++; $display("FAIL hold_no_retrigger: got %0d reset cycles expected 0", n_rises);
    end
    start_pg = 1'b0;
    for (int i = 0; i < 4; i++) step();
    start_pg = 1'b1;
    wait_rise();
    n_tests++;
    if (k_rise != REQ_TO_RST) begin
      n_fail++; $display("FAIL hold_repress: got %0d expected %0d", k_rise, REQ_TO_RST);
    end
    step();
    start_pg = 1'b0;
    bus.upg_done = 1'b1;
    step();
    bus.upg_done = 1'b0;
    step();
    n_tests++;
    if (act_stat !== {3'b010, 16'h0}) begin
      n_fail++; $display("FAIL hold_second_done: got %h expected %h", act_stat, {3'b010, 16'h0});
    end
    $display("[TB] hold_through: done");
  endtask

  initial begin
    bus.upg_wen = 1'b0;
    bus.upg_done = 1'b0;
    test_reset();
    test_debounce();
    test_prog_writes();
    test_done_same_cycle();
    test_done_on_entry();
    test_reset_mid_prog();
    test_hold_through();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_mode_ctrl.md
Name: prog_mode_ctrl

Overview:
- Sequences the CPU between normal execution and UART reprogramming, and arbitrates the instruction-memory and data-memory write ports between the CPU and the UART programmer.
- Sits in top between the start_pg button, the UART programmer (upg_* signals) and the CPU core / memory blocks.
- Generates the CPU reset (cpu_rst) and the programmer reset (upg_rst), so top needs no ad-hoc reset gluing.

Parameters:
DEBOUNCE_CYCLES, 100000, consecutive synchronized-high cycles on start_pg before a press is accepted (4 in simulation)
CNT_W, 17, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
MEM_ADDR_W, 14, word-address width of each memory

Ports:
clock  in  1  system clock
fpga_rst_n  in  1  asynchronous, active-low reset
start_pg  in  1  raw program-mode button, asynchronous to clock
upg_wen  in  1  programmer word-write strobe
upg_adr  in  15  programmer address; bit14 = 0 selects imem, 1 selects dmem; bits[13:0] are the word address
upg_dat  in  32  programmer write data
upg_done  in  1  programmer finished (level)
cpu_imem_addr  in  14  CPU fetch address
cpu_dmem_addr  in  14  CPU data address
cpu_dmem_wen  in  1  CPU data write enable
cpu_dmem_wdata  in  32  CPU write data
imem_addr  out  14  to imem
imem_wen  out  1  to imem
imem_wdata  out  32  to imem
dmem_addr  out  14  to dmem
dmem_wen  out  1  to dmem
dmem_wdata  out  32  to dmem
cpu_rst  out  1  active-high CPU reset
upg_rst  out  1  active-high programmer reset
prog_mode  out  1  high while the UART owns the memories
prog_words  out  16  count of words written in the current or most recent programming session

Behaviour:
- Reset values (asynchronous, while fpga_rst_n = 0): state = RUN, cpu_rst = 1, upg_rst = 1, prog_mode = 0, prog_words = 0, debounce counter = 0, synchronizers = 0.
- Reset release: cpu_rst drops to 0 on the first rising clock edge after fpga_rst_n goes high.
- Button synchronizer and debounce:
  - start_pg passes through a 2-FF synchronizer, then a counter.
  - The counter increments while the synchronized signal is 1, saturating at DEBOUNCE_CYCLES, and clears to 0 when it is 0.
  - pg_req is a single-cycle pulse on the cycle the counter reaches DEBOUNCE_CYCLES.
  - One pulse per press; the button must be released before it can fire again.
- State machine, 2-bit encoding (RUN=0, ARM=1, PROG=2, RELEASE=3):
  - RUN: CPU owns both memories; upg_rst = 1. On pg_req, go to ARM and set cpu_rst = 1 on the same edge.
  - ARM (exactly 1 cycle): clear prog_words to 0; set prog_mode = 1 and upg_rst = 0 on the exit edge; go to PROG.
  - PROG: UART owns both memories; cpu_rst = 1. Stay until upg_done = 1, then go to RELEASE.
  - RELEASE (exactly 1 cycle): prog_mode = 0, upg_rst = 1, cpu_rst stays 1. On the exit edge, cpu_rst = 0 and the state returns to RUN, so the CPU restarts from its reset PC.
- Port mux (combinational on the registered state):
  - UART-owned (ARM, PROG):
    - imem_addr and dmem_addr = upg_adr[13:0].
    - imem_wdata and dmem_wdata = upg_dat.
    - imem_wen = upg_wen & ~upg_adr[14].
    - dmem_wen = upg_wen & upg_adr[14].
    - In ARM both wen outputs are forced to 0.
  - CPU-owned (RUN, RELEASE):
    - imem_addr = cpu_imem_addr, imem_wen = 0, imem_wdata = 0.
    - dmem_addr = cpu_dmem_addr, dmem_wdata = cpu_dmem_wdata.
    - dmem_wen = cpu_dmem_wen & ~cpu_rst.
- prog_words: increments by 1 on every PROG-state cycle with upg_wen = 1, saturating at 16'hFFFF; it holds its value in RUN.
- Boundary conditions:
  - upg_wen and upg_done in the same cycle: the write is issued and counted, then the state goes to RELEASE.
  - pg_req in ARM, PROG or RELEASE: ignored (no queuing).
  - upg_done already high on entering PROG: leave after one PROG cycle; no write unless upg_wen is also high.
  - Reset asserted mid-PROG: immediate asynchronous return to RUN; the CPU regains the ports and all write enables fall in the same instant; prog_words = 0.
  - The CPU cannot write memory while cpu_rst is high.

Decomposition:
- Package prog_ctrl_pkg holds:
  - the state encoding constants (RUN, ARM, PROG, RELEASE);
  - UPG_ADR_W = 15, UPG_SEL_BIT = 14, MEM_ADDR_W = 14;
  - PROG_CNT_W = 16.
- One sub-module, btn_debounce (2-FF synchronizer plus counter; outputs the pg_req pulse), parameterised by DEBOUNCE_CYCLES and CNT_W.

Test Plan (DEBOUNCE_CYCLES = 4):
1. Pulse fpga_rst_n low for 1 cycle with start_pg = 0 -> cpu_rst = 1 during reset and 0 one edge after release; state RUN; upg_rst = 1; dmem_wen follows cpu_dmem_wen.
2. Bounce start_pg 1,0,1,0 on single cycles, then hold it high for 8 cycles -> exactly one pg_req, 6 cycles after the stable rise; cpu_rst = 1 on the next edge; prog_mode = 1 two edges later.
3. In PROG, write upg_adr = 15'h0003 / upg_dat = 32'h2008000A, then upg_adr = 15'h4005 / upg_dat = 32'hDEADBEEF -> imem_wen pulse at address 3, dmem_wen pulse at address 5; cpu_dmem_wen = 1 is ignored; prog_words = 2.
4. Assert upg_wen and upg_done in the same cycle -> write occurs; prog_words increments; one RELEASE cycle; cpu_rst falls on the following edge; upg_rst = 1; prog_mode = 0.
5. Pull fpga_rst_n low in PROG while upg_wen = 1 -> imem_wen/dmem_wen drop immediately; prog_words = 0; after release the state is RUN.
6. Hold start_pg high through an entire session and back into RUN -> no second session until start_pg is released and pressed again.
